// File: rtl/cpu_seq_pkg.sv
// Shared opcodes, FSM state type and flag bit positions for cpu_seq_core.
package cpu_seq_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_MOV = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JC  = 4'hA;
  localparam logic [3:0] OP_OUT = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {IDLE, F_OP, F_A, F_B, EXEC, HALT} state_t;

  localparam int unsigned FZ = 0;
  localparam int unsigned FC = 1;
  localparam int unsigned FN = 2;
  localparam int unsigned FV = 3;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/alu_unit.sv
// Combinational ALU: ADD/SUB/AND/OR/XOR with {V,N,C,Z} flags.
module alu_unit
  import cpu_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide   = '0;
    result = '0;
    flags  = '0;
    case (op)
      OP_ADD: begin
        wide      = {1'b0, a} + {1'b0, b};
        result    = wide[DATA_W-1:0];
        flags[FC] = wide[DATA_W];
        flags[FV] = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        // extra MSB of the widened difference is the borrow (b > a unsigned)
        wide      = {1'b0, a} - {1'b0, b};
        result    = wide[DATA_W-1:0];
        flags[FC] = wide[DATA_W];
        flags[FV] = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
    flags[FZ] = (result == '0);
    flags[FN] = result[DATA_W-1];
  end

endmodule

// File: rtl/cpu_seq_core.sv
// Fetch/decode/execute core: 3-word instructions over a ready/ack program-memory port.
module cpu_seq_core
  import cpu_seq_pkg::*;
#(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 6,
  parameter int unsigned       NREGS    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] alu_out,
  output logic [3:0]        flags,
  output logic              out_valid,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc_dbg
);

  localparam int unsigned RW = $clog2(NREGS);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc;
  logic [3:0]        op_q;
  logic [RW-1:0]     rd_idx;
  logic [RW-1:0]     rs_idx;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] alu_res;
  logic [3:0]        alu_flg;
  logic              fetching;
  logic              xfer;
  logic              take_jump;

  assign rs_idx   = b_q[RW-1:0];
  assign fetching = (state == F_OP) || (state == F_A) || (state == F_B);
  assign xfer     = fetching && mem_ack;
  assign mem_req  = fetching;
  assign mem_addr = pc;
  assign halted   = (state == HALT);
  assign pc_dbg   = pc;

  alu_unit #(.DATA_W(DATA_W)) u_alu (
    .a      (regs[rd_idx]),
    .b      (regs[rs_idx]),
    .op     (op_q),
    .result (alu_res),
    .flags  (alu_flg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = F_OP;
      F_OP:    if (mem_ack) state_nx = F_A;
      F_A:     if (mem_ack) state_nx = F_B;
      F_B:     if (mem_ack) state_nx = EXEC;
      EXEC:    state_nx = (op_q == OP_HLT) ? HALT : F_OP;
      HALT:    if (start) state_nx = F_OP;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    take_jump = 1'b0;
    case (op_q)
      OP_JMP:  take_jump = 1'b1;
      OP_JZ:   take_jump = flags[FZ];
      OP_JC:   take_jump = flags[FC];
      default: take_jump = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      op_q      <= OP_NOP;
      rd_idx    <= '0;
      b_q       <= '0;
      alu_out   <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      if (xfer) begin
        pc <= pc + ADDR_W'(1);
        case (state)
          F_OP:    op_q   <= mem_rdata[3:0];
          F_A:     rd_idx <= mem_rdata[RW-1:0];
          F_B:     b_q    <= mem_rdata;
          default: ;
        endcase
      end
      if ((state == IDLE || state == HALT) && start) pc <= RESET_PC;
      if (state == EXEC) begin
        if (is_alu_op(op_q)) begin
          regs[rd_idx] <= alu_res;
          alu_out      <= alu_res;
          flags        <= alu_flg;
        end
        case (op_q)
          OP_LDI:                regs[rd_idx] <= b_q;
          OP_MOV:                regs[rd_idx] <= regs[rs_idx];
          OP_JMP, OP_JZ, OP_JC:  if (take_jump) pc <= ADDR_W'(b_q);
          OP_OUT: begin
            alu_out   <= regs[rd_idx];
            out_valid <= 1'b1;
          end
          4'hC, 4'hD, 4'hE:      illegal <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_seq_core.sv
// Bench for cpu_seq_core: constant vectors, corner sequences and random programs vs an ISA model.
module tb_cpu_seq_core;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 6;
  localparam int unsigned NR = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [DW-1:0] alu_out;
  logic [3:0]    flags;
  logic          out_valid;
  logic          halted;
  logic          illegal;
  logic [AW-1:0] pc_dbg;

  always #5 clk = ~clk;

  cpu_seq_core #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR), .RESET_PC(6'd0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_out(alu_out), .flags(flags), .out_valid(out_valid), .halted(halted),
    .illegal(illegal), .pc_dbg(pc_dbg)
  );

  logic [7:0]    mem [64];
  int            total = 0;
  int            bad = 0;
  int unsigned   max_delay = 0;
  bit            hold_ack = 1'b0;
  logic [AW-1:0] addr_log [$];
  logic [7:0]    obs_out [$];
  int            obs_illegal = 0;

  logic [7:0]    m_regs [4];
  logic [3:0]    m_flags;
  logic [7:0]    m_outs [$];
  int            m_illegal;
  logic [5:0]    m_pc;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flg;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin : responder
    bit          hv;
    logic [AW-1:0] ha;
    int unsigned wc;
    hv = 1'b0; ha = '0; wc = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && hv) check("addr_stable", mem_addr, ha);
      if (mem_req) begin
        if (!hv) begin
          hv = 1'b1;
          ha = mem_addr;
          wc = $urandom_range(max_delay, 0);
        end
        if (!hold_ack && wc == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          addr_log.push_back(mem_addr);
          hv = 1'b0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 8'($urandom);
          if (wc > 0) wc--;
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        hv = 1'b0;
      end
    end
  end

  initial begin : monitor
    bit prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        obs_out.push_back(alu_out);
        check("out_valid_width", prev_ov, 1'b0);
      end
      if (illegal) obs_illegal++;
      prev_ov = out_valid;
    end
  end

  function automatic bit out_of_range(input int s);
    return (s > 127) || (s < -128);
  endfunction

  // Instruction-level interpreter of the ISA, run over the current memory image.
  task automatic model_run();
    logic [5:0] pc;
    logic [7:0] op, a, b, x, y, res;
    int         n, r, s;
    bit         done;
    pc = 6'd0; n = 0; done = 1'b0;
    m_outs.delete();
    m_illegal = 0;
    while (!done && n < 2000) begin
      op = mem[pc];
      a  = mem[6'(pc + 1)];
      b  = mem[6'(pc + 2)];
      pc = 6'(pc + 3);
      n++;
      x = m_regs[a[1:0]];
      y = m_regs[b[1:0]];
      case (op[3:0])
        4'h1: m_regs[a[1:0]] = b;
        4'h2: begin
          r = int'(x) + int'(y);
          s = int'($signed(x)) + int'($signed(y));
          res = 8'(r % 256);
          m_regs[a[1:0]] = res;
          m_flags = {out_of_range(s), res[7], r > 255, res == 8'd0};
        end
        4'h3: begin
          r = int'(x) - int'(y);
          s = int'($signed(x)) - int'($signed(y));
          res = 8'((r + 256) % 256);
          m_regs[a[1:0]] = res;
          m_flags = {out_of_range(s), res[7], int'(y) > int'(x), res == 8'd0};
        end
        4'h4, 4'h5, 4'h6: begin
          res = (op[3:0] == 4'h4) ? (x & y) : (op[3:0] == 4'h5) ? (x | y) : (x ^ y);
          m_regs[a[1:0]] = res;
          m_flags = {1'b0, res[7], 1'b0, res == 8'd0};
        end
        4'h7: m_regs[a[1:0]] = y;
        4'h8: pc = b[5:0];
        4'h9: if (m_flags[0]) pc = b[5:0];
        4'hA: if (m_flags[1]) pc = b[5:0];
        4'hB: m_outs.push_back(x);
        4'hC, 4'hD, 4'hE: m_illegal++;
        4'hF: done = 1'b1;
        default: ;
      endcase
    end
    m_pc = pc;
  endtask

  task automatic fill_hlt();
    for (int i = 0; i < 64; i++) mem[i] = 8'h0F;
  endtask

  task automatic put(input int addr, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    mem[addr % 64]       = op;
    mem[(addr + 1) % 64] = a;
    mem[(addr + 2) % 64] = b;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'd0;
    m_flags = 4'd0;
  endtask

  task automatic wait_halt(input string tag);
    int cyc;
    cyc = 0;
    while (!halted && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_halt_reached"}, halted, 1'b1);
  endtask

  task automatic pulse_start();
    obs_out.delete();
    obs_illegal = 0;
    addr_log.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_n_out"}, obs_out.size(), m_outs.size());
    for (int i = 0; i < obs_out.size() && i < m_outs.size(); i++)
      check({tag, "_out_val"}, obs_out[i], m_outs[i]);
    check({tag, "_flags"}, flags, m_flags);
    check({tag, "_pc"}, pc_dbg, m_pc);
    check({tag, "_illegal_cnt"}, obs_illegal, m_illegal);
    check({tag, "_no_req_halted"}, mem_req, 1'b0);
  endtask

  task automatic run_prog(input string tag);
    model_run();
    pulse_start();
    wait_halt(tag);
    compare_model(tag);
  endtask

  task automatic gen_random();
    logic [3:0] op;
    logic [7:0] b;
    fill_hlt();
    for (int i = 0; i < 19; i++) begin
      op = 4'($urandom_range(14, 0));
      if (op >= 4'h8 && op <= 4'hA) b = 8'(3 * $urandom_range(19, i + 1));
      else                          b = 8'($urandom);
      put(3 * i, {4'($urandom), op}, 8'($urandom), b);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"}, mem_req, 1'b0);
    check({tag, "_alu_out"}, alu_out, 8'h00);
    check({tag, "_flags"}, flags, 4'h0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_halted"}, halted, 1'b0);
    check({tag, "_illegal"}, illegal, 1'b0);
    check({tag, "_pc"}, pc_dbg, 6'd0);
  endtask

  initial begin : main
    int w;
    vecs[0] = '{4'h2, 8'h7F, 8'h01, 8'h80, 4'b1100};
    vecs[1] = '{4'h3, 8'h05, 8'h05, 8'h00, 4'b0001};
    vecs[2] = '{4'h3, 8'h00, 8'h01, 8'hFF, 4'b0110};
    vecs[3] = '{4'h2, 8'hFF, 8'h01, 8'h00, 4'b0011};
    vecs[4] = '{4'h3, 8'h80, 8'h01, 8'h7F, 4'b1000};
    vecs[5] = '{4'h4, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    vecs[6] = '{4'h5, 8'h0F, 8'h80, 8'h8F, 4'b0100};
    vecs[7] = '{4'h6, 8'hAA, 8'hAA, 8'h00, 4'b0001};
    vecs[8] = '{4'h2, 8'h80, 8'h80, 8'h00, 4'b1011};
    vecs[9] = '{4'h2, 8'h40, 8'h40, 8'h80, 4'b1100};

    // Reset state and zero-wait fetch timing.
    rst = 1'b1;
    max_delay = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    model_reset();
    fill_hlt();
    put(0, 8'h01, 8'h00, 8'h7F);
    put(3, 8'h01, 8'h01, 8'h01);
    put(6, 8'h02, 8'h00, 8'h01);
    put(9, 8'h0B, 8'h00, 8'h00);
    model_run();
    pulse_start();
    check("t_fetch0", {mem_req, mem_addr}, {1'b1, 6'd0});
    @(negedge clk) check("t_fetch1", {mem_req, mem_addr}, {1'b1, 6'd1});
    @(negedge clk) check("t_fetch2", {mem_req, mem_addr}, {1'b1, 6'd2});
    @(negedge clk) check("t_exec_noreq", mem_req, 1'b0);
    @(negedge clk) check("t_fetch3", {mem_req, mem_addr}, {1'b1, 6'd3});
    wait_halt("t_add");
    compare_model("t_add");
    check("t_add_out", (obs_out.size() > 0) ? obs_out[0] : 8'hxx, 8'h80);
    check("t_add_flags", flags, 4'b1100);

    // Constant ALU vectors under random ack latency.
    max_delay = 3;
    for (int i = 0; i < 10; i++) begin
      fill_hlt();
      put(0, 8'h01, 8'h00, vecs[i].a);
      put(3, 8'h01, 8'h01, vecs[i].b);
      put(6, {4'h0, vecs[i].op}, 8'h00, 8'h01);
      put(9, 8'h0B, 8'h00, 8'h00);
      run_prog("vec");
      check("vec_n_out", obs_out.size(), 1);
      if (obs_out.size() > 0) check("vec_result", obs_out[0], vecs[i].res);
      check("vec_flags", flags, vecs[i].flg);
    end

    // Taken JZ, then SUB 0-1 at the jump target.
    fill_hlt();
    put(0, 8'h01, 8'h00, 8'h05);
    put(3, 8'h01, 8'h01, 8'h05);
    put(6, 8'h03, 8'h00, 8'h01);
    put(9, 8'h09, 8'h00, 8'h20);
    put(12, 8'h0B, 8'h00, 8'h00);
    put(32, 8'h01, 8'h01, 8'h01);
    put(35, 8'h03, 8'h00, 8'h01);
    put(38, 8'h0B, 8'h00, 8'h00);
    run_prog("jz");
    check("jz_target_addr", (addr_log.size() > 12) ? addr_log[12] : 6'hxx, 6'h20);
    check("jz_n_out", obs_out.size(), 1);
    if (obs_out.size() > 0) check("jz_sub_result", obs_out[0], 8'hFF);
    check("jz_flags", flags, 4'b0110);
    check("jz_pc", pc_dbg, 6'h2C);

    // Illegal opcode, then HLT holds without requests.
    fill_hlt();
    put(0, 8'h0C, 8'h00, 8'h00);
    run_prog("ill");
    check("ill_pulses", obs_illegal, 1);
    check("ill_next_addr", (addr_log.size() > 3) ? addr_log[3] : 6'hxx, 6'd3);
    check("ill_pc", pc_dbg, 6'd6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("halt_hold", {halted, mem_req}, 2'b10);
    end

    // Restart from HALT keeps registers.
    fill_hlt();
    put(0, 8'h01, 8'h02, 8'h5A);
    run_prog("keep_a");
    fill_hlt();
    put(0, 8'h0B, 8'h02, 8'h00);
    run_prog("keep_b");
    check("keep_first_addr", (addr_log.size() > 0) ? addr_log[0] : 6'hxx, 6'd0);
    if (obs_out.size() > 0) check("keep_r2", obs_out[0], 8'h5A);

    // Instruction straddling the PC wrap (words 63, 0, 1).
    fill_hlt();
    put(0, 8'h01, 8'h01, 8'h3C);
    put(3, 8'h08, 8'h00, 8'h3F);
    mem[63] = 8'h0B;
    run_prog("wrap");
    check("wrap_n_out", obs_out.size(), 1);
    if (obs_out.size() > 0) check("wrap_out", obs_out[0], 8'h3C);
    check("wrap_illegal", obs_illegal, 1);
    check("wrap_pc", pc_dbg, 6'd8);

    // Random programs against the model.
    for (int k = 0; k < 8; k++) begin
      gen_random();
      run_prog("rnd");
    end

    // Reset while a fetch is outstanding.
    hold_ack = 1'b1;
    fill_hlt();
    pulse_start();
    w = 0;
    while (!mem_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("mid_req_seen", mem_req, 1'b1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    hold_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_idle", {mem_req, halted, pc_dbg}, 8'd0);
    end
    fill_hlt();
    put(0, 8'h0B, 8'h03, 8'h00);
    run_prog("post_rst");
    if (obs_out.size() > 0) check("post_rst_regs_clear", obs_out[0], 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
